// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard control unit.
//   hazard_ctrl_t  : per-pipeline-register load enables (load_pc is the MSB)
//   hazard_state_t : memory-response tracking FSM state
package hazard_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
    } hazard_ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,   // neither side served yet
        ST_I_DONE = 2'd1,   // imem served and held, waiting on dmem
        ST_D_DONE = 2'd2    // dmem served and held, waiting on imem
    } hazard_state_t;

    localparam hazard_ctrl_t CTRL_NONE = 5'b00000;
    localparam hazard_ctrl_t CTRL_ALL  = 5'b11111;
    // Load-use bubble: freeze PC and IF/ID, let ID/EX onward advance.
    localparam hazard_ctrl_t CTRL_LU   = 5'b00111;

    // A source only matches when it is actually read.
    function automatic logic src_match(input logic use_src,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_src && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of pipeline status inputs and hazard control outputs.
//   master : pipeline side (drives status, reads controls/counters)
//   slave  : hazard_ctrl_unit side
interface hazard_ctrl_unit_if;
    import hazard_ctrl_pkg::*;

    logic               imem_read;
    logic               imem_resp;
    logic               dmem_read;
    logic               dmem_write;
    logic               dmem_resp;
    logic               id_ex_is_load;
    logic [4:0]         id_ex_rd;
    logic [4:0]         if_id_rs1;
    logic [4:0]         if_id_rs2;
    logic               if_id_use_rs1;
    logic               if_id_use_rs2;
    logic               ex_br_taken;

    hazard_ctrl_t       ctrl;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               ir_hold_en;
    logic               ir_sel_hold;
    logic               dmem_hold_en;
    logic               dmem_sel_hold;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   lu_bubbles;
    logic [CNT_W-1:0]   br_flushes;

    modport master (
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               id_ex_is_load, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_use_rs1, if_id_use_rs2, ex_br_taken,
        input  ctrl, flush_if_id, flush_id_ex, ir_hold_en, ir_sel_hold,
               dmem_hold_en, dmem_sel_hold, stall_cycles, lu_bubbles, br_flushes
    );

    modport slave (
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               id_ex_is_load, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_use_rs1, if_id_use_rs2, ex_br_taken,
        output ctrl, flush_if_id, flush_id_ex, ir_hold_en, ir_sel_hold,
               dmem_hold_en, dmem_sel_hold, stall_cycles, lu_bubbles, br_flushes
    );

endinterface

// File: rtl/hazard_ctrl_unit_perf_ctr.sv
// perf_ctr: free-running event counter, wraps modulo 2^W.
//   clk     : clock
//   i_clr_n : synchronous active-low clear (wins over enable)
//   i_en    : count this cycle
//   o_cnt   : current count
module perf_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_clr_n)  r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/bubble control for a 5-stage pipeline.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : status in (imem/dmem handshakes, ID/EX load info, IF/ID sources,
//           branch redirect); control out (load enables, flushes, I/D hold
//           buffer control, performance counters)
// The FSM remembers which side of a split I/D miss has already been served
// so the served data is parked in a hold buffer and not re-requested; the
// stall drops in the same cycle the last outstanding response arrives.
module hazard_ctrl_unit
    import hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    hazard_ctrl_unit_if.slave bus
);

    hazard_state_t r_state, w_next;

    logic w_i_done, w_d_done;
    logic w_i_need, w_i_miss, w_d_need, w_d_miss, w_mem_stall;
    logic w_lu, w_br;
    logic w_stall_en, w_lu_en, w_br_en;
    logic [CNT_W-1:0] w_stall_cnt, w_lu_cnt, w_br_cnt;

    assign w_i_done    = (r_state == ST_I_DONE);
    assign w_d_done    = (r_state == ST_D_DONE);
    assign w_i_need    = bus.imem_read & ~w_i_done;
    assign w_i_miss    = w_i_need & ~bus.imem_resp;
    assign w_d_need    = (bus.dmem_read | bus.dmem_write) & ~w_d_done;
    assign w_d_miss    = w_d_need & ~bus.dmem_resp;
    assign w_mem_stall = w_i_miss | w_d_miss;

    // x0 is never a real producer, so rd == 0 cannot cause a load-use stall.
    assign w_lu = bus.id_ex_is_load && (bus.id_ex_rd != 5'd0) &&
                  (src_match(bus.if_id_use_rs1, bus.if_id_rs1, bus.id_ex_rd) ||
                   src_match(bus.if_id_use_rs2, bus.if_id_rs2, bus.id_ex_rd));
    assign w_br = bus.ex_br_taken;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (bus.imem_resp && w_d_miss)      w_next = ST_I_DONE;
                else if (bus.dmem_resp && w_i_miss) w_next = ST_D_DONE;
            end
            ST_I_DONE: if (bus.dmem_resp) w_next = ST_RUN;
            ST_D_DONE: if (bus.imem_resp) w_next = ST_RUN;
            default:   w_next = ST_RUN;
        endcase
    end

    // Output logic; everything is forced quiet while reset is asserted.
    always_comb begin
        bus.ctrl          = CTRL_NONE;
        bus.flush_if_id   = 1'b0;
        bus.flush_id_ex   = 1'b0;
        bus.ir_hold_en    = 1'b0;
        bus.ir_sel_hold   = 1'b0;
        bus.dmem_hold_en  = 1'b0;
        bus.dmem_sel_hold = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                ST_RUN: begin
                    bus.ir_hold_en   = bus.imem_resp & w_d_miss;
                    bus.dmem_hold_en = bus.dmem_resp & w_i_miss;
                end
                ST_I_DONE: bus.ir_sel_hold   = 1'b1;
                ST_D_DONE: bus.dmem_sel_hold = 1'b1;
                default: ;
            endcase
            // Priority: memory stall > branch redirect > load-use > none.
            // The stall freezes every register, so no flush can slip through.
            if (w_mem_stall) begin
                bus.ctrl = CTRL_NONE;
            end else if (w_br) begin
                bus.ctrl        = CTRL_ALL;
                bus.flush_if_id = 1'b1;
                bus.flush_id_ex = 1'b1;
            end else if (w_lu) begin
                bus.ctrl        = CTRL_LU;
                bus.flush_id_ex = 1'b1;
            end else begin
                bus.ctrl = CTRL_ALL;
            end
        end
    end

    assign w_stall_en = rst_n & w_mem_stall;
    assign w_br_en    = rst_n & ~w_mem_stall & w_br;
    assign w_lu_en    = rst_n & ~w_mem_stall & ~w_br & w_lu;

    perf_ctr #(.W(CNT_W)) u_stall_ctr (
        .clk(clk), .i_clr_n(rst_n), .i_en(w_stall_en), .o_cnt(w_stall_cnt));
    perf_ctr #(.W(CNT_W)) u_lu_ctr (
        .clk(clk), .i_clr_n(rst_n), .i_en(w_lu_en), .o_cnt(w_lu_cnt));
    perf_ctr #(.W(CNT_W)) u_br_ctr (
        .clk(clk), .i_clr_n(rst_n), .i_en(w_br_en), .o_cnt(w_br_cnt));

    assign bus.stall_cycles = w_stall_cnt;
    assign bus.lu_bubbles   = w_lu_cnt;
    assign bus.br_flushes   = w_br_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Each step drives one cycle of
// inputs and pushes the expected outputs; the expectation is popped and
// compared on the following falling edge. Counter expectations are
// accumulated from the expected outputs of earlier steps.
module tb_hazard_ctrl_unit;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if bus();

    hazard_ctrl_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ctl bits: [6]imem_read [5]imem_resp [4]dmem_read [3]dmem_write
    //           [2]dmem_resp [1]id_ex_is_load [0]ex_br_taken
    localparam logic [6:0] IDLE = 7'b000_0000;
    localparam logic [6:0] IM   = 7'b100_0000;  // imem read, no response
    localparam logic [6:0] IMR  = 7'b110_0000;  // imem read + response
    localparam logic [6:0] IDM  = 7'b101_0000;  // imem + dmem, no responses
    localparam logic [6:0] IRDM = 7'b111_0000;  // imem resp, dmem missing
    localparam logic [6:0] IMDR = 7'b101_0100;  // dmem resp, imem missing
    localparam logic [6:0] LD   = 7'b000_0010;
    localparam logic [6:0] LDBR = 7'b000_0011;
    localparam logic [6:0] DMBR = 7'b001_0001;  // dmem read missing + branch
    localparam logic [6:0] DRBR = 7'b001_0101;  // dmem read resp + branch
    localparam logic [6:0] DWR  = 7'b000_1100;  // dmem write + resp
    localparam logic [6:0] DR   = 7'b001_0100;  // dmem read + resp

    localparam logic [4:0] C_ALL  = 5'b11111;
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b00111;

    typedef struct {
        string       tag;
        logic [4:0]  ctrl;
        logic [1:0]  fl;    // {flush_if_id, flush_id_ex}
        logic [3:0]  hs;    // {ir_hold_en, ir_sel_hold, dmem_hold_en, dmem_sel_hold}
        bit          chk_cnt;
        logic [31:0] sc, lu, bf;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_sc = 0, m_lu = 0, m_bf = 0;
    bit          cnt_known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [4:0] rd, rs1, rs2,
                         input logic [1:0] use_src);
        bus.imem_read     = ctl[6];
        bus.imem_resp     = ctl[5];
        bus.dmem_read     = ctl[4];
        bus.dmem_write    = ctl[3];
        bus.dmem_resp     = ctl[2];
        bus.id_ex_is_load = ctl[1];
        bus.ex_br_taken   = ctl[0];
        bus.id_ex_rd      = rd;
        bus.if_id_rs1     = rs1;
        bus.if_id_rs2     = rs2;
        bus.if_id_use_rs1 = use_src[1];
        bus.if_id_use_rs2 = use_src[0];
    endtask

    task automatic push_exp(input string tag, input logic [4:0] c,
                            input logic [1:0] fl, input logic [3:0] hs);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.fl = fl; e.hs = hs;
        e.chk_cnt = cnt_known; e.sc = m_sc; e.lu = m_lu; e.bf = m_bf;
        sb.push_back(e);
        // Counters seen next cycle: cleared by reset, else advanced by this cycle.
        if (!rst_n) begin
            m_sc = 0; m_lu = 0; m_bf = 0; cnt_known = 1;
        end else begin
            if (c == C_NONE) m_sc++;
            if (fl[1])       m_bf++;
            else if (fl[0])  m_lu++;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            tests++; fails++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".ctrl"}, 32'(bus.ctrl), 32'(e.ctrl));
            chk({e.tag, ".flush"}, 32'({bus.flush_if_id, bus.flush_id_ex}), 32'(e.fl));
            chk({e.tag, ".hold"}, 32'({bus.ir_hold_en, bus.ir_sel_hold,
                                       bus.dmem_hold_en, bus.dmem_sel_hold}), 32'(e.hs));
            if (e.chk_cnt) begin
                chk({e.tag, ".stall_cycles"}, bus.stall_cycles, e.sc);
                chk({e.tag, ".lu_bubbles"},   bus.lu_bubbles,   e.lu);
                chk({e.tag, ".br_flushes"},   bus.br_flushes,   e.bf);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] ctl,
                        input logic [4:0] rd, rs1, rs2, input logic [1:0] use_src,
                        input logic [4:0] c, input logic [1:0] fl, input logic [3:0] hs);
        drive(ctl, rd, rs1, rs2, use_src);
        push_exp(tag, c, fl, hs);
        tick();
    endtask

    initial begin
        drive(IDLE, 0, 0, 0, 2'b00);
        @(posedge clk); #1;

        // Reset, including with requests outstanding
        step("rst0",     IDLE, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("rst_busy", IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        rst_n = 1'b1;

        // First cycle out of reset: response is a fresh response
        step("post_rst", IMR,  0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);
        step("idle",     IDLE, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);

        // imem miss for 3 cycles then response
        for (int i = 0; i < 3; i++)
            step("imiss", IM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("imiss_rsp", IMR, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);

        // Split miss, imem served first (I_DONE path)
        step("split_i1",  IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("split_i2",  IRDM, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b1000);
        step("split_i3",  IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0100);
        step("split_i4",  IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0100);
        step("split_i5",  IMDR, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0100);
        step("split_i6",  IDLE, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);

        // Split miss, dmem served first (D_DONE path)
        step("split_d1",  IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("split_d2",  IMDR, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0010);
        step("split_d3",  IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0001);
        step("split_d4",  IRDM, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0001);
        step("split_d5",  IDLE, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);

        // Load-use
        step("lu_rs2",    LD, 5, 0, 5,  2'b01, C_LU,  2'b01, 4'b0000);
        step("lu_rd0",    LD, 0, 0, 0,  2'b11, C_ALL, 2'b00, 4'b0000);
        step("lu_unused", LD, 7, 7, 3,  2'b01, C_ALL, 2'b00, 4'b0000);
        step("lu_rs1",    LD, 7, 7, 3,  2'b10, C_LU,  2'b01, 4'b0000);
        step("lu_noload", IDLE, 9, 9, 9, 2'b11, C_ALL, 2'b00, 4'b0000);

        // Branch overrides load-use
        step("br_lu",     LDBR, 5, 0, 5, 2'b01, C_ALL, 2'b11, 4'b0000);

        // Branch during dmem miss: frozen until response, then flushed
        step("br_dmiss1", DMBR, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("br_dmiss2", DMBR, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("br_drsp",   DRBR, 0, 0, 0, 2'b00, C_ALL,  2'b11, 4'b0000);
        step("dwr_rsp",   DWR,  0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);

        // Reset while parked in I_DONE with 7 stall cycles counted
        rst_n = 1'b0;
        step("rst2",      IDLE, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            step("pre_idone", IDM, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        step("to_idone",  IRDM, 0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b1000);
        rst_n = 1'b0;
        step("rst_idone", IDM,  0, 0, 0, 2'b00, C_NONE, 2'b00, 4'b0000);
        rst_n = 1'b1;
        step("after_rst", IDLE, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);
        step("run_drsp",  DR,   0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);
        step("final",     IDLE, 0, 0, 0, 2'b00, C_ALL,  2'b00, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
